// File: rtl/osc_bank_if.sv
// Configuration handshake and mixed-sample output bundle for osc_bank.
// master drives voice configuration and observes the sample stream; slave is the oscillator bank.
interface osc_bank_if #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 32,
    parameter int SAMPLE_W   = 16
);
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [VIDX_W-1:0]   cfg_voice;
    logic                cfg_enable;
    logic [1:0]          cfg_mode;
    logic [PHASE_W-1:0]  cfg_phase_inc;
    logic [7:0]          cfg_duty;
    logic [7:0]          cfg_gain;
    logic                cfg_phase_rst;
    logic [SAMPLE_W-1:0] sample_out;
    logic                sample_valid;
    logic                busy;

    modport master (
        output cfg_valid, cfg_voice, cfg_enable, cfg_mode, cfg_phase_inc,
               cfg_duty, cfg_gain, cfg_phase_rst,
        input  cfg_ready, sample_out, sample_valid, busy
    );

    modport slave (
        input  cfg_valid, cfg_voice, cfg_enable, cfg_mode, cfg_phase_inc,
               cfg_duty, cfg_gain, cfg_phase_rst,
        output cfg_ready, sample_out, sample_valid, busy
    );
endinterface

// File: rtl/osc_bank.sv
// Multi-voice phase-accumulator tone generator: voices are evaluated one per clock
// at each sample frame and mixed with saturation into a single signed sample.
module osc_bank #(
    parameter int NUM_VOICES        = 4,
    parameter int CYCLES_PER_SAMPLE = 2272,
    parameter int PHASE_W           = 32,
    parameter int SAMPLE_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    osc_bank_if.slave   bus
);
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CNT_W  = (CYCLES_PER_SAMPLE > 1) ? $clog2(CYCLES_PER_SAMPLE) : 1;
    localparam int PROD_W = SAMPLE_W + 9;
    localparam int ACC_W  = SAMPLE_W + 9 + $clog2(NUM_VOICES);

    localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
    localparam logic [SAMPLE_W-1:0]     MSB  = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, VOICE, MIX} state_t;

    typedef struct packed {
        logic               en;
        logic [1:0]         mode;
        logic [PHASE_W-1:0] inc;
        logic [7:0]         duty;
        logic [7:0]         gain;
    } voice_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [VIDX_W-1:0]        vidx;
    logic signed [ACC_W-1:0]  acc;
    voice_t                   voice_q [NUM_VOICES];
    logic [PHASE_W-1:0]       phase_q [NUM_VOICES];
    logic [SAMPLE_W-1:0]      sample_q;
    logic                     valid_q;

    voice_t                   cur;
    logic [SAMPLE_W-1:0]      p;
    logic [SAMPLE_W-2:0]      tri_t;
    logic signed [SAMPLE_W-1:0] wave;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] contrib;
    logic signed [ACC_W-1:0]  contrib_ext;
    logic signed [ACC_W-1:0]  acc_next;
    logic [SAMPLE_W-1:0]      sat_acc;

    // Waveform uses the pre-increment phase of the voice being evaluated.
    always_comb begin
        cur   = voice_q[vidx];
        p     = phase_q[vidx][PHASE_W-1 -: SAMPLE_W];
        tri_t = p[SAMPLE_W-1] ? ~p[SAMPLE_W-2:0] : p[SAMPLE_W-2:0];
        wave  = '0;
        unique case (cur.mode)
            2'b00: wave = p[SAMPLE_W-1] ? MSB : ~MSB;
            2'b01: wave = (p < {cur.duty, {(SAMPLE_W-8){1'b0}}}) ? ~MSB : MSB;
            2'b10: wave = p ^ MSB;
            2'b11: wave = {tri_t, 1'b0} ^ MSB;
        endcase
        prod        = wave * $signed({1'b0, cur.gain});
        contrib     = prod >>> 7;
        contrib_ext = cur.en ? ACC_W'(contrib) : '0;
        acc_next    = acc + contrib_ext;
    end

    always_comb begin
        if (acc > SMAX)      sat_acc = SMAX[SAMPLE_W-1:0];
        else if (acc < SMIN) sat_acc = SMIN[SAMPLE_W-1:0];
        else                 sat_acc = acc[SAMPLE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            vidx     <= '0;
            acc      <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                voice_q[i] <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            cnt     <= (cnt == CNT_W'(CYCLES_PER_SAMPLE-1)) ? '0 : cnt + 1'b1;
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Config lands only between frames, so a frame never sees a torn voice.
                    if (bus.cfg_valid && int'(bus.cfg_voice) < NUM_VOICES) begin
                        voice_q[bus.cfg_voice] <= '{en: bus.cfg_enable, mode: bus.cfg_mode,
                                                   inc: bus.cfg_phase_inc, duty: bus.cfg_duty,
                                                   gain: bus.cfg_gain};
                        if (bus.cfg_phase_rst) phase_q[bus.cfg_voice] <= '0;
                    end
                    if (cnt == '0) begin
                        state <= VOICE;
                        vidx  <= '0;
                        acc   <= '0;
                    end
                end
                VOICE: begin
                    acc <= acc_next;
                    if (cur.en) phase_q[vidx] <= phase_q[vidx] + cur.inc;
                    if (vidx == VIDX_W'(NUM_VOICES-1)) state <= MIX;
                    else                               vidx  <= vidx + 1'b1;
                end
                MIX: begin
                    sample_q <= sat_acc;
                    valid_q  <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = (state != IDLE);
    assign bus.cfg_ready    = (state == IDLE);
endmodule

// File: tb/tb_osc_bank.sv
// Randomized check of osc_bank against a frame-level arithmetic model, plus directed waveform checks.
module tb_osc_bank;
    localparam int NV  = 4;
    localparam int CPS = 16;
    localparam int PW  = 32;
    localparam int SW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    osc_bank_if #(.NUM_VOICES(NV), .PHASE_W(PW), .SAMPLE_W(SW)) bus_if ();

    osc_bank #(.NUM_VOICES(NV), .CYCLES_PER_SAMPLE(CPS), .PHASE_W(PW), .SAMPLE_W(SW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // model state
    int          mcnt = 0;
    bit          m_en    [NV];
    int          m_mode  [NV];
    logic [31:0] m_inc   [NV];
    int          m_duty  [NV];
    int          m_gain  [NV];
    logic [31:0] m_phase [NV];
    longint      m_pend  = 0;
    bit          m_live  = 0;
    bit          m_valid = 0;
    logic [15:0] m_out   = '0;
    bit          m_wr_acc = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic longint wave_of(input int mode, input longint p, input int duty);
        case (mode)
            0: return (p < 32768) ? 32767 : -32768;
            1: return (p < duty * 256) ? 32767 : -32768;
            2: return p - 32768;
            default: return (p < 32768) ? 2 * p - 32768 : 2 * (65535 - p) - 32768;
        endcase
    endfunction

    function automatic longint contrib_of(input longint w, input int gain);
        longint prod;
        prod = w * gain;
        return (prod >= 0) ? prod / 128 : -((-prod + 127) / 128);
    endfunction

    task automatic model_step();
        int     c;
        int     v;
        longint sum;
        c = mcnt;
        m_wr_acc = 0;
        if (!rst) begin
            for (int i = 0; i < NV; i++) begin
                m_en[i] = 0; m_mode[i] = 0; m_inc[i] = '0;
                m_duty[i] = 0; m_gain[i] = 0; m_phase[i] = '0;
            end
            mcnt = 0; m_live = 0; m_valid = 0; m_out = '0;
            return;
        end
        if (bus_if.cfg_valid && (c == 0 || c >= NV + 2)) begin
            m_wr_acc = 1;
            v = int'(bus_if.cfg_voice);
            if (v < NV) begin
                m_en[v]   = bus_if.cfg_enable;
                m_mode[v] = int'(bus_if.cfg_mode);
                m_inc[v]  = bus_if.cfg_phase_inc;
                m_duty[v] = int'(bus_if.cfg_duty);
                m_gain[v] = int'(bus_if.cfg_gain);
                if (bus_if.cfg_phase_rst) m_phase[v] = '0;
            end
        end
        m_valid = 0;
        if (c == 0) begin
            sum = 0;
            for (int i = 0; i < NV; i++) begin
                if (m_en[i]) begin
                    sum += contrib_of(wave_of(m_mode[i], longint'(m_phase[i] >> 16), m_duty[i]), m_gain[i]);
                    m_phase[i] = m_phase[i] + m_inc[i];
                end
            end
            if (sum > 32767)       m_pend = 32767;
            else if (sum < -32768) m_pend = -32768;
            else                   m_pend = sum;
            m_live = 1;
        end
        if (c == NV + 1 && m_live) begin
            m_out   = m_pend[15:0];
            m_valid = 1;
            m_live  = 0;
        end
        mcnt = (c == CPS - 1) ? 0 : c + 1;
    endtask

    task automatic cycle();
        bit ready;
        @(posedge clk);
        model_step();
        @(negedge clk);
        ready = (mcnt == 0 || mcnt >= NV + 2);
        chk("cfg_ready", bus_if.cfg_ready, ready);
        chk("busy", bus_if.busy, !ready);
        chk("sample_valid", bus_if.sample_valid, m_valid);
        chk("sample_out", bus_if.sample_out, m_out);
    endtask

    task automatic cfg_write(input int voice, input bit en, input int mode, input logic [31:0] inc,
                             input int duty, input int gain, input bit prst);
        bit done;
        done = 0;
        bus_if.cfg_valid     = 1'b1;
        bus_if.cfg_voice     = 2'(voice);
        bus_if.cfg_enable    = en;
        bus_if.cfg_mode      = 2'(mode);
        bus_if.cfg_phase_inc = inc;
        bus_if.cfg_duty      = 8'(duty);
        bus_if.cfg_gain      = 8'(gain);
        bus_if.cfg_phase_rst = prst;
        for (int i = 0; i < 64 && !done; i++) begin
            cycle();
            done = m_wr_acc;
        end
        bus_if.cfg_valid = 1'b0;
        if (!done) chk("cfg_accept_timeout", 0, 1);
    endtask

    task automatic wait_frame(output logic [15:0] s);
        bit got;
        got = 0;
        s   = 'x;
        for (int i = 0; i < 2 * CPS + 4 && !got; i++) begin
            cycle();
            if (bus_if.sample_valid) begin
                got = 1;
                s   = bus_if.sample_out;
            end
        end
        if (!got) chk("frame_timeout", 0, 1);
    endtask

    task automatic wait_cnt(input int target);
        for (int i = 0; i < 2 * CPS && mcnt != target; i++) cycle();
    endtask

    logic [15:0] s;
    logic [15:0] exp16;

    initial begin
        bus_if.cfg_valid = 1'b0; bus_if.cfg_voice = '0; bus_if.cfg_enable = 1'b0;
        bus_if.cfg_mode = '0; bus_if.cfg_phase_inc = '0; bus_if.cfg_duty = '0;
        bus_if.cfg_gain = '0; bus_if.cfg_phase_rst = 1'b0;

        rst = 1'b0;
        cycle(); cycle();
        chk("rst_out", bus_if.sample_out, 0);
        chk("rst_ready", bus_if.cfg_ready, 1);
        rst = 1'b1;

        // square
        cfg_write(0, 1, 0, 32'h1000_0000, 0, 128, 1);
        for (int k = 0; k < 16; k++) begin
            wait_frame(s);
            exp16 = (k < 8) ? 16'h7FFF : 16'h8000;
            chk($sformatf("square_f%0d", k), s, exp16);
        end
        // saw
        cfg_write(0, 1, 2, 32'h1000_0000, 0, 128, 1);
        for (int k = 0; k < 16; k++) begin
            wait_frame(s);
            exp16 = 16'h8000 + 16'(k * 16'h1000);
            chk($sformatf("saw_f%0d", k), s, exp16);
        end
        // pulse, unity then half gain
        cfg_write(0, 1, 1, 32'h1000_0000, 8'h40, 128, 1);
        for (int k = 0; k < 16; k++) begin
            wait_frame(s);
            exp16 = (k < 4) ? 16'h7FFF : 16'h8000;
            chk($sformatf("pulse_f%0d", k), s, exp16);
        end
        cfg_write(0, 1, 1, 32'h1000_0000, 8'h40, 64, 1);
        for (int k = 0; k < 16; k++) begin
            wait_frame(s);
            exp16 = (k < 4) ? 16'h3FFF : 16'hC000;
            chk($sformatf("pulse_g64_f%0d", k), s, exp16);
        end
        // four squares: saturation then cancellation
        cfg_write(0, 1, 0, 32'h0, 0, 128, 1);
        cfg_write(1, 1, 0, 32'h0, 0, 128, 1);
        cfg_write(2, 1, 0, 32'h8000_0000, 0, 128, 1);
        cfg_write(3, 1, 0, 32'h8000_0000, 0, 128, 1);
        wait_frame(s);
        chk("mix4_sat", s, 16'h7FFF);
        wait_frame(s);
        chk("mix4_f1", s, 16'hFFFE);

        // write held off during a frame, phase restart
        for (int v = 1; v < NV; v++) cfg_write(v, 0, 0, 32'h0, 0, 0, 0);
        cfg_write(0, 1, 2, 32'h1000_0000, 0, 128, 1);
        wait_frame(s); wait_frame(s); wait_frame(s);
        chk("saw_pre", s, 16'hA000);
        wait_cnt(2);
        chk("busy_ready_low", bus_if.cfg_ready, 0);
        cfg_write(0, 1, 2, 32'h1000_0000, 0, 128, 1);
        wait_frame(s);
        chk("saw_restart", s, 16'h8000);

        // reset mid-frame
        wait_cnt(2);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        chk("midrst_out", bus_if.sample_out, 0);
        wait_frame(s);
        chk("post_rst_zero", s, 16'h0000);

        // randomized traffic against the model
        for (int it = 0; it < 400; it++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r < 9) begin
                cfg_write(int'($urandom_range(0, NV - 1)), 1'($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 3)), $urandom(), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end else if (r < 19) begin
                int n;
                n = int'($urandom_range(1, 20));
                for (int j = 0; j < n; j++) cycle();
            end else begin
                rst = 1'b0;
                cycle();
                rst = 1'b1;
            end
        end
        for (int j = 0; j < 2 * CPS; j++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
